// File: rtl/npc_mc_ctrl_if.sv
// Fetch and data-memory request/response channels of the multi-cycle NPC sequencer.
// Master is the sequencer; slave is the memory side.
interface npc_mc_ctrl_if #(
   parameter int XLEN = 32
);
   logic            if_req_valid;
   logic            if_req_ready;
   logic [XLEN-1:0] if_req_addr;
   logic            if_resp_valid;
   logic [31:0]     if_resp_data;
   logic            mem_req_valid;
   logic            mem_req_ready;
   logic            mem_req_we;
   logic            mem_resp_valid;
   logic [XLEN-1:0] mem_resp_data;

   modport master (
      output if_req_valid, if_req_addr, mem_req_valid, mem_req_we,
      input  if_req_ready, if_resp_valid, if_resp_data,
             mem_req_ready, mem_resp_valid, mem_resp_data
   );

   modport slave (
      input  if_req_valid, if_req_addr, mem_req_valid, mem_req_we,
      output if_req_ready, if_resp_valid, if_resp_data,
             mem_req_ready, mem_resp_valid, mem_resp_data
   );
endinterface

// File: rtl/npc_mc_ctrl.sv
// Multi-cycle NPC sequencer: IF -> EX -> (MEM) -> WB with PC ownership, commit gating,
// halt/illegal/timeout detection and cycle/instret counters.
module npc_mc_ctrl #(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000,
   parameter int unsigned     TIMEOUT  = 255,
   parameter int              CNT_W    = 64
) (
   input  logic             clk,
   input  logic             rst,
   npc_mc_ctrl_if.master    bus,
   output logic [31:0]      inst,
   input  logic             is_load,
   input  logic             is_store,
   input  logic             is_ebreak,
   input  logic             is_illegal,
   input  logic             reg_wen_in,
   input  logic             csr_wen_in,
   input  logic [XLEN-1:0]  dnpc_in,
   output logic [XLEN-1:0]  load_data,
   output logic [XLEN-1:0]  pc,
   output logic             gpr_wen,
   output logic             csr_wen,
   output logic             commit,
   output logic             halted,
   output logic             error,
   output logic [1:0]       err_cause,
   output logic [CNT_W-1:0] cycle_cnt,
   output logic [CNT_W-1:0] instret_cnt
);
   typedef enum logic [2:0] {
      S_IF_REQ, S_IF_WAIT, S_EX, S_MEM_REQ, S_MEM_WAIT, S_WB, S_HALT, S_ERR
   } state_t;

   // Last waiting cycle index; a response on this cycle still wins over the timeout.
   localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

   state_t      state, state_nx;
   logic [15:0] wait_cnt;
   logic [1:0]  cause_nx;
   logic        wait_expired;

   assign wait_expired = (wait_cnt == WAIT_LAST);

   always_comb begin
      state_nx = state;
      cause_nx = 2'd0;
      case (state)
         S_IF_REQ:   if (bus.if_req_ready) state_nx = S_IF_WAIT;
         S_IF_WAIT: begin
            if (bus.if_resp_valid) state_nx = S_EX;
            else if (wait_expired) begin
               state_nx = S_ERR;
               cause_nx = 2'd2;
            end
         end
         S_EX: begin
            if (is_illegal) begin
               state_nx = S_ERR;
               cause_nx = 2'd1;
            end else if (is_load || is_store) state_nx = S_MEM_REQ;
            else state_nx = S_WB;
         end
         S_MEM_REQ:  if (bus.mem_req_ready) state_nx = S_MEM_WAIT;
         S_MEM_WAIT: begin
            if (bus.mem_resp_valid) state_nx = S_WB;
            else if (wait_expired) begin
               state_nx = S_ERR;
               cause_nx = 2'd3;
            end
         end
         S_WB:       state_nx = is_ebreak ? S_HALT : S_IF_REQ;
         S_HALT:     state_nx = S_HALT;
         S_ERR:      state_nx = S_ERR;
         default:    state_nx = S_ERR;
      endcase
   end

   // Outputs are masked while rst is high so nothing is requested or committed during reset.
   assign bus.if_req_valid  = (state == S_IF_REQ) && !rst;
   assign bus.if_req_addr   = pc;
   assign bus.mem_req_valid = (state == S_MEM_REQ) && !rst;
   assign bus.mem_req_we    = (state == S_MEM_REQ) && !rst && is_store;
   assign commit            = (state == S_WB) && !rst;
   assign gpr_wen           = commit && reg_wen_in;
   assign csr_wen           = commit && csr_wen_in;

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_IF_REQ;
         pc          <= RESET_PC;
         inst        <= '0;
         load_data   <= '0;
         cycle_cnt   <= '0;
         instret_cnt <= '0;
         halted      <= 1'b0;
         error       <= 1'b0;
         err_cause   <= 2'd0;
         wait_cnt    <= '0;
      end else begin
         state <= state_nx;
         if (state == S_IF_WAIT || state == S_MEM_WAIT) wait_cnt <= wait_cnt + 16'd1;
         else wait_cnt <= '0;
         if (state == S_IF_WAIT && bus.if_resp_valid) inst <= bus.if_resp_data;
         if (state == S_MEM_WAIT && bus.mem_resp_valid && is_load) load_data <= bus.mem_resp_data;
         if (state == S_WB) begin
            pc          <= dnpc_in;
            instret_cnt <= instret_cnt + CNT_W'(1);
            if (is_ebreak) halted <= 1'b1;
         end
         if (state_nx == S_ERR && state != S_ERR) begin
            error     <= 1'b1;
            err_cause <= cause_nx;
         end
         if (state != S_HALT && state != S_ERR) cycle_cnt <= cycle_cnt + CNT_W'(1);
      end
   end
endmodule

// File: tb/tb_npc_mc_ctrl.sv
// Directed and randomized bench for npc_mc_ctrl; expectations come from a per-instruction
// timing model (phase lengths from handshake latencies) plus architectural PC/counter state.
module tb_npc_mc_ctrl;
   localparam int          XLEN = 32;
   localparam logic [31:0] RPC  = 32'h8000_0000;
   localparam int          TMO  = 8;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   npc_mc_ctrl_if #(.XLEN(XLEN)) bus();

   logic [31:0]     inst;
   logic            is_load, is_store, is_ebreak, is_illegal, reg_wen_in, csr_wen_in;
   logic [XLEN-1:0] dnpc_in, load_data, pc;
   logic            gpr_wen, csr_wen, commit, halted, error;
   logic [1:0]      err_cause;
   logic [63:0]     cycle_cnt, instret_cnt;

   npc_mc_ctrl #(.XLEN(XLEN), .RESET_PC(RPC), .TIMEOUT(TMO), .CNT_W(64)) dut (
      .clk(clk), .rst(rst), .bus(bus), .inst(inst),
      .is_load(is_load), .is_store(is_store), .is_ebreak(is_ebreak), .is_illegal(is_illegal),
      .reg_wen_in(reg_wen_in), .csr_wen_in(csr_wen_in), .dnpc_in(dnpc_in),
      .load_data(load_data), .pc(pc), .gpr_wen(gpr_wen), .csr_wen(csr_wen), .commit(commit),
      .halted(halted), .error(error), .err_cause(err_cause),
      .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
   );

   // Architectural reference state
   logic [31:0]     m_pc, m_ld;
   longint unsigned m_cyc, m_ret;
   bit              m_stop, m_halt;
   int              n_chk = 0, n_pass = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   task automatic step();
      if (!m_stop) m_cyc++;
      @(posedge clk);
      #1;
   endtask

   // Non-WB cycle: only the named request valid may be high, nothing commits.
   task automatic outs(input bit ifv, input bit memv);
      #1;
      chk("if_req_valid", bus.if_req_valid, ifv);
      if (ifv) chk("if_req_addr", bus.if_req_addr, m_pc);
      chk("mem_req_valid", bus.mem_req_valid, memv);
      chk("commit_idle", commit, 0);
      chk("gpr_wen_idle", gpr_wen, 0);
      chk("csr_wen_idle", csr_wen, 0);
   endtask

   task automatic clear_inputs();
      bus.if_req_ready = 0; bus.if_resp_valid = 0; bus.if_resp_data = '0;
      bus.mem_req_ready = 0; bus.mem_resp_valid = 0; bus.mem_resp_data = '0;
      is_load = 0; is_store = 0; is_ebreak = 0; is_illegal = 0;
      reg_wen_in = 0; csr_wen_in = 0; dnpc_in = '0;
   endtask

   task automatic do_reset(input bit stale);
      rst = 1;
      clear_inputs();
      @(posedge clk); #1;
      chk("rst_if_valid", bus.if_req_valid, 0);
      chk("rst_commit", commit, 0);
      @(posedge clk); #1;
      rst = 0;
      m_pc = RPC; m_ld = '0; m_cyc = 0; m_ret = 0; m_stop = 0; m_halt = 0;
      chk("rst_pc", pc, RPC);
      chk("rst_inst", inst, 0);
      chk("rst_load_data", load_data, 0);
      chk("rst_cycle", cycle_cnt, 0);
      chk("rst_instret", instret_cnt, 0);
      chk("rst_halted", halted, 0);
      chk("rst_error", error, 0);
      chk("rst_cause", err_cause, 0);
      if (stale) begin
         bus.mem_resp_valid = 1; bus.if_resp_valid = 1; bus.if_resp_data = 32'hBAD0BAD0;
         repeat (2) begin outs(1, 0); step(); end
         chk("stale_inst", inst, 0);
         chk("stale_load_data", load_data, 0);
         clear_inputs();
      end
   endtask

   // kind: 0 alu, 1 load, 2 store, 3 ebreak, 4 illegal
   // mode: 0 normal, 1 fetch timeout, 2 mem timeout, 3 reset during MEM_WAIT
   task automatic run_instr(input int kind, input int ifs, input int ifl, input int ms, input int ml,
                            input logic [31:0] word, input logic [31:0] ldata,
                            input logic [31:0] dnpc, input bit rw, input bit cw, input int mode);
      is_load = (kind == 1); is_store = (kind == 2); is_ebreak = (kind == 3);
      is_illegal = (kind == 4); reg_wen_in = rw; csr_wen_in = cw; dnpc_in = dnpc;
      repeat (ifs) begin bus.if_req_ready = 0; outs(1, 0); step(); end
      bus.if_req_ready = 1; outs(1, 0); step(); bus.if_req_ready = 0;
      if (mode == 1) begin
         repeat (TMO) begin chk("fto_no_err_yet", error, 0); outs(0, 0); step(); end
         m_stop = 1;
         chk("fto_error", error, 1);
         chk("fto_cause", err_cause, 2);
         chk("fto_halted", halted, 0);
         chk("fto_cycle", cycle_cnt, m_cyc);
         outs(0, 0); step();
         chk("fto_cycle_frozen", cycle_cnt, m_cyc);
         return;
      end
      repeat (ifl) begin outs(0, 0); step(); end
      bus.if_resp_valid = 1; bus.if_resp_data = word; outs(0, 0); step(); bus.if_resp_valid = 0;
      outs(0, 0);
      chk("ex_inst", inst, word);
      step();
      if (kind == 4) begin
         m_stop = 1;
         outs(0, 0);
         chk("ill_error", error, 1);
         chk("ill_cause", err_cause, 1);
         chk("ill_instret", instret_cnt, m_ret);
         chk("ill_cycle", cycle_cnt, m_cyc);
         return;
      end
      if (kind == 1 || kind == 2) begin
         repeat (ms) begin
            bus.mem_req_ready = 0; outs(0, 1);
            chk("mem_we_hold", bus.mem_req_we, kind == 2); step();
         end
         bus.mem_req_ready = 1; outs(0, 1); chk("mem_we", bus.mem_req_we, kind == 2); step();
         bus.mem_req_ready = 0;
         if (mode == 2) begin
            repeat (TMO) begin outs(0, 0); step(); end
            m_stop = 1;
            chk("mto_error", error, 1);
            chk("mto_cause", err_cause, 3);
            chk("mto_instret", instret_cnt, m_ret);
            return;
         end
         if (mode == 3) begin
            repeat (2) begin outs(0, 0); step(); end
            do_reset(1);
            return;
         end
         repeat (ml) begin outs(0, 0); step(); end
         bus.mem_resp_valid = 1; bus.mem_resp_data = ldata; outs(0, 0); step();
         bus.mem_resp_valid = 0;
         if (kind == 1) m_ld = ldata;
      end
      #1;
      chk("wb_commit", commit, 1);
      chk("wb_gpr_wen", gpr_wen, rw);
      chk("wb_csr_wen", csr_wen, cw);
      chk("wb_if_valid", bus.if_req_valid, 0);
      chk("wb_load_data", load_data, m_ld);
      chk("wb_cycle", cycle_cnt, m_cyc);
      chk("wb_instret", instret_cnt, m_ret);
      chk("wb_pc_old", pc, m_pc);
      step();
      m_pc = dnpc; m_ret++;
      if (kind == 3) begin m_stop = 1; m_halt = 1; end
      chk("post_pc", pc, m_pc);
      chk("post_instret", instret_cnt, m_ret);
      chk("post_halted", halted, m_halt);
      chk("post_error", error, 0);
      clear_inputs();
   endtask

   initial begin
      logic [31:0] t, w, d;
      int kind;
      rst = 1; clear_inputs();
      do_reset(0);

      // addi, zero-wait
      run_instr(0, 0, 0, 0, 0, 32'h0010_0093, '0, RPC + 32'd4, 1, 0, 0);
      // load: request stalled 3 cycles, response 2 cycles later
      run_instr(1, 0, 0, 3, 2, 32'h0000_2083, 32'hDEAD_BEEF, m_pc + 32'd4, 1, 0, 0);
      // store leaves load_data alone
      run_instr(2, 0, 0, 1, 1, 32'h0010_2023, 32'h1234_5678, m_pc + 32'd4, 0, 0, 0);

      for (int i = 0; i < 40; i++) begin
         kind = int'($urandom_range(0, 2));
         t = $urandom; t[1:0] = 2'b00;
         w = $urandom; d = $urandom;
         if ($urandom_range(0, 3) != 0) t = m_pc + 32'd4;
         run_instr(kind, int'($urandom_range(0, 3)), int'($urandom_range(0, 6)),
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 6)),
                   w, d, t, 1'($urandom), 1'($urandom), 0);
      end
      // responses on the last wait cycle before timeout still proceed
      run_instr(0, 0, TMO - 1, 0, 0, 32'h0000_0013, '0, m_pc + 32'd4, 1, 1, 0);
      run_instr(1, 0, 0, 0, TMO - 1, 32'h0000_2003, 32'hCAFE_F00D, m_pc + 32'd4, 1, 0, 0);

      // ebreak at RESET_PC+0x10
      do_reset(0);
      repeat (4) run_instr(0, 0, 0, 0, 0, 32'h0000_0013, '0, m_pc + 32'd4, 1, 0, 0);
      chk("pc_before_ebreak", pc, 32'h8000_0010);
      run_instr(3, 0, 0, 0, 0, 32'h0010_0073, '0, 32'h8000_0014, 0, 0, 0);
      chk("halt_pc", pc, 32'h8000_0014);
      bus.if_req_ready = 1;
      repeat (20) begin outs(0, 0); step(); end
      chk("halt_cycle_frozen", cycle_cnt, m_cyc);
      chk("halt_sticky", halted, 1);
      chk("halt_no_error", error, 0);

      do_reset(0);
      run_instr(0, 0, 0, 0, 0, 32'h0000_0013, '0, m_pc + 32'd4, 1, 0, 1);
      do_reset(0);
      run_instr(4, 1, 1, 0, 0, 32'hFFFF_FFFF, '0, m_pc + 32'd4, 1, 1, 0);
      do_reset(0);
      run_instr(2, 0, 0, 0, 0, 32'h0010_2023, '0, m_pc + 32'd4, 0, 0, 2);
      do_reset(0);
      run_instr(1, 0, 0, 1, 0, 32'h0000_2083, 32'h5555_AAAA, m_pc + 32'd4, 1, 0, 3);
      run_instr(0, 0, 0, 0, 0, 32'h0010_0093, '0, m_pc + 32'd4, 1, 0, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
